// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - DDS frequency-sweep sequencer driving cnt_incr INCR and DAC SCALE
// Optional continuous (looping) sweep mode enabled by defining DDS_SWEEP_CONT_EN.
module dds_sweep_ctrl #(
  parameter int INCR_WL  = 7,
  parameter int DWELL_WL = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [INCR_WL-1:0]  i_f_start,
  input  logic [INCR_WL-1:0]  i_f_stop,
  input  logic [INCR_WL-1:0]  i_f_step,
  input  logic [DWELL_WL-1:0] i_dwell,
  input  logic [1:0]          i_scale_in,
  output logic [INCR_WL-1:0]  o_incr,
  output logic [1:0]          o_scale,
  output logic                o_busy,
  output logic                o_step_stb,
  output logic                o_done
);

  typedef enum logic {S_IDLE, S_DWELL} state_t;

  localparam logic [INCR_WL-1:0]  INCR_ONE  = INCR_WL'(1);
  localparam logic [DWELL_WL-1:0] DWELL_ONE = DWELL_WL'(1);

  state_t               r_state, w_state_nxt;
  logic [INCR_WL-1:0]   r_incr, w_incr_nxt;
  logic [1:0]           r_scale, w_scale_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_step_stb, w_step_stb_nxt;
  logic                 r_done, w_done_nxt;
  logic [DWELL_WL-1:0]  r_cnt, w_cnt_nxt;
  logic [INCR_WL-1:0]   r_f_start_l, w_f_start_l_nxt;
  logic [INCR_WL-1:0]   r_f_stop_l, w_f_stop_l_nxt;
  logic [INCR_WL-1:0]   r_f_step_l, w_f_step_l_nxt;
  logic [DWELL_WL-1:0]  r_dwell_l, w_dwell_l_nxt;

  // One extra bit keeps the step sum from wrapping before the clamp compare.
  logic [INCR_WL:0]     w_sum;
  logic                 w_dwell_end;

  assign w_sum       = {1'b0, r_incr} + {1'b0, r_f_step_l};
  assign w_dwell_end = (r_cnt == (r_dwell_l - DWELL_ONE));

  always_comb begin
    w_state_nxt      = r_state;
    w_incr_nxt       = r_incr;
    w_scale_nxt      = r_scale;
    w_busy_nxt       = r_busy;
    w_step_stb_nxt   = 1'b0;
    w_done_nxt       = 1'b0;
    w_cnt_nxt        = r_cnt;
    w_f_start_l_nxt  = r_f_start_l;
    w_f_stop_l_nxt   = r_f_stop_l;
    w_f_step_l_nxt   = r_f_step_l;
    w_dwell_l_nxt    = r_dwell_l;

    case (r_state)
      S_IDLE: begin
        w_scale_nxt = i_scale_in;
        if (i_start && !i_stop) begin
          w_f_start_l_nxt = i_f_start;
          w_f_stop_l_nxt  = i_f_stop;
          w_f_step_l_nxt  = (i_f_step == '0) ? INCR_ONE : i_f_step;
          w_dwell_l_nxt   = (i_dwell == '0) ? DWELL_ONE : i_dwell;
          w_incr_nxt      = i_f_start;
          w_step_stb_nxt  = 1'b1;
          w_busy_nxt      = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_DWELL;
        end
      end

      S_DWELL: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else if (w_dwell_end) begin
          w_cnt_nxt = '0;
          if (r_incr >= r_f_stop_l) begin
`ifdef DDS_SWEEP_CONT_EN
            w_incr_nxt     = r_f_start_l;
            w_step_stb_nxt = 1'b1;
            w_done_nxt     = 1'b1;
`else
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
`endif
          end else begin
            w_incr_nxt     = (w_sum >= {1'b0, r_f_stop_l}) ? r_f_stop_l : w_sum[INCR_WL-1:0];
            w_step_stb_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + DWELL_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_incr      <= '0;
      r_scale     <= '0;
      r_busy      <= 1'b0;
      r_step_stb  <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_f_start_l <= '0;
      r_f_stop_l  <= '0;
      r_f_step_l  <= INCR_ONE;
      r_dwell_l   <= DWELL_ONE;
    end else begin
      r_state     <= w_state_nxt;
      r_incr      <= w_incr_nxt;
      r_scale     <= w_scale_nxt;
      r_busy      <= w_busy_nxt;
      r_step_stb  <= w_step_stb_nxt;
      r_done      <= w_done_nxt;
      r_cnt       <= w_cnt_nxt;
      r_f_start_l <= w_f_start_l_nxt;
      r_f_stop_l  <= w_f_stop_l_nxt;
      r_f_step_l  <= w_f_step_l_nxt;
      r_dwell_l   <= w_dwell_l_nxt;
    end
  end

  assign o_incr     = r_incr;
  assign o_scale    = r_scale;
  assign o_busy     = r_busy;
  assign o_step_stb = r_step_stb;
  assign o_done     = r_done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - directed-vector bench for dds_sweep_ctrl
// Build with DDS_SWEEP_CONT_EN defined to exercise continuous mode instead of one-shot finishes.
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [6:0]  f_start;
  logic [6:0]  f_stop;
  logic [6:0]  f_step;
  logic [15:0] dwell;
  logic [1:0]  scale_in;
  logic [6:0]  incr;
  logic [1:0]  scale;
  logic        busy;
  logic        step_stb;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  dds_sweep_ctrl #(.INCR_WL(7), .DWELL_WL(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_stop     (stop),
    .i_f_start  (f_start),
    .i_f_stop   (f_stop),
    .i_f_step   (f_step),
    .i_dwell    (dwell),
    .i_scale_in (scale_in),
    .o_incr     (incr),
    .o_scale    (scale),
    .o_busy     (busy),
    .o_step_stb (step_stb),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int fs, input int fe, input int st, input int dw, input int sc);
    f_start  = 7'(fs);
    f_stop   = 7'(fe);
    f_step   = 7'(st);
    dwell    = 16'(dw);
    scale_in = 2'(sc);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_incr"}, int'(incr), 0);
    check({tag, "_scale"}, int'(scale), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_stb"}, int'(step_stb), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    f_start  = '0;
    f_stop   = '0;
    f_step   = '0;
    dwell    = '0;
    scale_in = 2'd3;
    #1;
    check_idle_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_scale_follow", int'(scale), 3);
    scale_in = 2'd0;
    tick();

    // Ramp 10..40 in steps of 10, three cycles per word.
    do_start(10, 40, 10, 3, 0);
    for (int j = 0; j < 12; j++) begin
      check("t2_incr", int'(incr), 10 + 10 * (j / 3));
      check("t2_stb", int'(step_stb), (j % 3 == 0) ? 1 : 0);
      check("t2_done", int'(done), 0);
      tick();
    end
`ifdef DDS_SWEEP_CONT_EN
    check("t6_done_pass1", int'(done), 1);
    check("t6_busy_pass1", int'(busy), 1);
    check("t6_incr_wrap", int'(incr), 10);
    check("t6_stb_wrap", int'(step_stb), 1);
    tick();
    for (int j = 1; j < 12; j++) begin
      check("t6_incr", int'(incr), 10 + 10 * (j / 3));
      check("t6_done_mid", int'(done), 0);
      tick();
    end
    check("t6_done_pass2", int'(done), 1);
    check("t6_incr_wrap2", int'(incr), 10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t6_busy_stop", int'(busy), 0);
    check("t6_done_stop", int'(done), 0);
    tick();
`else
    check("t2_done_end", int'(done), 1);
    check("t2_busy_end", int'(busy), 0);
    check("t2_incr_end", int'(incr), 40);
    check("t2_stb_end", int'(step_stb), 0);
    tick();
    check("t2_done_pulse", int'(done), 0);

    // Clamp at 120 instead of wrapping 115+15 past 7 bits.
    do_start(100, 120, 15, 1, 0);
    check("t3_incr0", int'(incr), 100);
    tick();
    check("t3_incr1", int'(incr), 115);
    tick();
    check("t3_incr2", int'(incr), 120);
    check("t3_stb2", int'(step_stb), 1);
    tick();
    check("t3_done", int'(done), 1);
    check("t3_incr_end", int'(incr), 120);
    tick();

    // Zero step and zero dwell behave as one.
    do_start(100, 103, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      check("t3b_incr", int'(incr), 100 + j);
      check("t3b_stb", int'(step_stb), 1);
      tick();
    end
    check("t3b_done", int'(done), 1);
    check("t3b_busy", int'(busy), 0);
    tick();

    // Single-point sweep with SCALE frozen until back in IDLE.
    do_start(50, 20, 5, 2, 2);
    check("t5_incr0", int'(incr), 50);
    check("t5_stb0", int'(step_stb), 1);
    check("t5_scale0", int'(scale), 2);
    scale_in = 2'd1;
    tick();
    check("t5_incr1", int'(incr), 50);
    check("t5_stb1", int'(step_stb), 0);
    check("t5_scale1", int'(scale), 2);
    tick();
    check("t5_done", int'(done), 1);
    check("t5_busy", int'(busy), 0);
    check("t5_scale2", int'(scale), 2);
    tick();
    check("t5_scale_idle", int'(scale), 1);
    check("t5_done_pulse", int'(done), 0);
`endif

    // Abort mid-sweep; START during BUSY is ignored.
    do_start(10, 40, 10, 3, 0);
    start   = 1'b1;
    f_start = 7'd77;
    tick();
    start = 1'b0;
    check("t4_ign_incr", int'(incr), 10);
    check("t4_ign_stb", int'(step_stb), 0);
    check("t4_ign_busy", int'(busy), 1);
    tick();
    tick();
    check("t4_incr20", int'(incr), 20);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_stop_busy", int'(busy), 0);
    check("t4_stop_incr", int'(incr), 20);
    check("t4_stop_done", int'(done), 0);
    check("t4_stop_stb", int'(step_stb), 0);
    tick();
    tick();
    tick();
    check("t4_idle_done", int'(done), 0);
    check("t4_idle_incr", int'(incr), 20);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("t4_both_busy", int'(busy), 0);
    check("t4_both_stb", int'(step_stb), 0);

    // Asynchronous reset in the middle of a sweep.
    do_start(10, 40, 10, 3, 2);
    tick();
    tick();
    tick();
    check("t1_pre_incr", int'(incr), 20);
    #2;
    rst = 1'b1;
    #1;
    check_idle_zero("t1_async");
    #1;
    rst = 1'b0;
    tick();
    check("t1_post_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
